spi_clk_gen: RTL and testbench

Parametrised digital SPI serial-clock generator; successor to the fixed-ratio PLL-based SPI clock.
Derives SCK from refclk with a runtime-programmable divider, all four CPOL/CPHA modes and burst length.
Provides launch and sample strobes in the refclk domain.
Keeps the familiar stdby/extlock contract so SPI masters in the design can swap over with minimal glue.

---
 rtl/spi_clk_pkg.sv | 21 ++
 rtl/spi_clk_lock.sv | 44 ++++
 rtl/spi_clk_gen.sv | 153 +++++++++++++++
 tb/tb_spi_clk_gen.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_clk_pkg.sv
// Shared constants for the SPI serial-clock generator: FSM encoding, SPI modes, defaults.
// No logic; imported by the generator, its lock tracker and the bench.
package spi_clk_pkg;

    localparam int DEF_DIV_W       = 8;
    localparam int DEF_CNT_W       = 6;
    localparam int DEF_LOCK_CYCLES = 16;

    typedef logic [1:0] fsm_t;

    localparam fsm_t ST_IDLE = 2'd0;
    localparam fsm_t ST_RUN  = 2'd1;
    localparam fsm_t ST_TAIL = 2'd2;

    // {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_lock.sv
// Divider-stability tracker: extlock rises after LOCK_CYCLES idle cycles of unchanged div.
// Latency: reload on the cycle after a div change or standby; frozen (not updated) outside idle.
// Backpressure: none; the generator simply refuses start while extlock is low.
module spi_clk_lock
    import spi_clk_pkg::*;
#(
    parameter int DIV_W       = DEF_DIV_W,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic             refclk,
    input  logic             reset,
    input  logic             idle,
    input  logic             stdby,
    input  logic [DIV_W-1:0] div,
    output logic [DIV_W-1:0] div_q,
    output logic             extlock
);

    localparam int LCW = $clog2(LOCK_CYCLES + 1);
    localparam logic [LCW-1:0] LOCK_INIT = LCW'(LOCK_CYCLES);
    localparam logic [LCW-1:0] LOCK_ONE  = LCW'(1);

    logic [LCW-1:0] lock_cnt;

    always_ff @(posedge refclk or negedge reset) begin
        if (!reset) begin
            div_q    <= '0;
            lock_cnt <= LOCK_INIT;
            extlock  <= 1'b0;
        end else if (idle) begin
            if (stdby || (div != div_q)) begin
                div_q    <= div;
                lock_cnt <= LOCK_INIT;
                extlock  <= 1'b0;
            end else if (lock_cnt != '0) begin
                lock_cnt <= lock_cnt - LOCK_ONE;
                extlock  <= (lock_cnt == LOCK_ONE);
            end else begin
                extlock  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_clk_gen.sv
// SPI SCK generator with launch/sample strobes; optional free-running bursts under SPI_CLK_CONT_EN.
// Latency: first SCK edge div+1 cycles after busy rises; done div+1 cycles after the last edge.
// Backpressure: start ignored while busy, unlocked or in standby; stdby freezes a running burst.
module spi_clk_gen
    import spi_clk_pkg::*;
#(
    parameter int DIV_W       = DEF_DIV_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic             refclk,
    input  logic             reset,
    input  logic             stdby,
    input  logic [DIV_W-1:0] div,
    input  logic             cpol,
    input  logic             cpha,
    input  logic [CNT_W-1:0] nbits,
    input  logic             start,
`ifdef SPI_CLK_CONT_EN
    input  logic             cont,
`endif
    output logic             busy,
    output logic             done,
    output logic             sck,
    output logic             shift_stb,
    output logic             sample_stb,
    output logic             extlock
);

    localparam int EW = CNT_W + 2;
    localparam logic [EW-1:0]    MAX_EDGES = {1'b1, {(CNT_W + 1){1'b0}}};
    localparam logic [EW-1:0]    EDGE_ONE  = EW'(1);
    localparam logic [DIV_W-1:0] HALF_ONE  = DIV_W'(1);

    fsm_t             state;
    logic [DIV_W-1:0] half_cnt;
    logic [DIV_W-1:0] div_l;
    logic [DIV_W-1:0] div_q;
    logic [EW-1:0]    edge_cnt;
    logic [EW-1:0]    burst_edges;
    logic             lead_q;
    logic             cpha_l;
    logic             idle;
    logic             accept;
    logic             last_edge;
`ifdef SPI_CLK_CONT_EN
    logic             cont_l;
`endif

    assign idle        = (state == ST_IDLE);
    assign accept      = start && extlock && !stdby;
    assign burst_edges = (nbits == '0) ? MAX_EDGES : {1'b0, nbits, 1'b0};

    // A free-running burst only ends on a trailing edge, so sck always settles back at cpol.
`ifdef SPI_CLK_CONT_EN
    assign last_edge = cont_l ? (!lead_q && !cont) : (edge_cnt == EDGE_ONE);
`else
    assign last_edge = (edge_cnt == EDGE_ONE);
`endif

    spi_clk_lock #(
        .DIV_W       (DIV_W),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_lock (
        .refclk  (refclk),
        .reset   (reset),
        .idle    (idle),
        .stdby   (stdby),
        .div     (div),
        .div_q   (div_q),
        .extlock (extlock)
    );

    always_ff @(posedge refclk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            half_cnt   <= '0;
            div_l      <= '0;
            edge_cnt   <= '0;
            lead_q     <= 1'b0;
            cpha_l     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sck        <= 1'b0;
            shift_stb  <= 1'b0;
            sample_stb <= 1'b0;
`ifdef SPI_CLK_CONT_EN
            cont_l     <= 1'b0;
`endif
        end else begin
            done       <= 1'b0;
            shift_stb  <= 1'b0;
            sample_stb <= 1'b0;
            case (state)
                ST_IDLE: begin
                    sck <= cpol;
                    if (accept) begin
                        state     <= ST_RUN;
                        busy      <= 1'b1;
                        half_cnt  <= div_q;
                        div_l     <= div_q;
                        cpha_l    <= cpha;
                        edge_cnt  <= burst_edges;
                        lead_q    <= 1'b1;
                        // cpha=0 needs bit 0 on the wire before the first (sampling) edge.
                        shift_stb <= !cpha;
`ifdef SPI_CLK_CONT_EN
                        cont_l    <= cont;
`endif
                    end
                end
                ST_RUN: begin
                    if (!stdby) begin
                        if (half_cnt == '0) begin
                            sck      <= ~sck;
                            half_cnt <= div_l;
                            edge_cnt <= edge_cnt - EDGE_ONE;
                            lead_q   <= ~lead_q;
                            if (lead_q) begin
                                sample_stb <= !cpha_l;
                                shift_stb  <= cpha_l;
                            end else begin
                                sample_stb <= cpha_l;
                                shift_stb  <= !cpha_l && !last_edge;
                            end
                            if (last_edge) begin
                                state <= ST_TAIL;
                            end
                        end else begin
                            half_cnt <= half_cnt - HALF_ONE;
                        end
                    end
                end
                ST_TAIL: begin
                    if (!stdby) begin
                        if (half_cnt == '0) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            half_cnt <= half_cnt - HALF_ONE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_clk_gen.sv
// Bench for spi_clk_gen: per-cycle comparison against an arithmetic burst model.
// Inputs change 1 time unit after the rising edge; outputs are observed at the same point.
module tb_spi_clk_gen;
    import spi_clk_pkg::*;

    localparam int LOCK_CYCLES = DEF_LOCK_CYCLES;
    localparam int MAX_BITS    = 1 << DEF_CNT_W;

    logic       refclk = 1'b0;
    logic       reset;
    logic       stdby;
    logic [7:0] div;
    logic       cpol;
    logic       cpha;
    logic [5:0] nbits;
    logic       start;
`ifdef SPI_CLK_CONT_EN
    logic       cont;
`endif
    logic       busy;
    logic       done;
    logic       sck;
    logic       shift_stb;
    logic       sample_stb;
    logic       extlock;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 refclk = ~refclk;

    spi_clk_gen dut (
        .refclk     (refclk),
        .reset      (reset),
        .stdby      (stdby),
        .div        (div),
        .cpol       (cpol),
        .cpha       (cpha),
        .nbits      (nbits),
        .start      (start),
`ifdef SPI_CLK_CONT_EN
        .cont       (cont),
`endif
        .busy       (busy),
        .done       (done),
        .sck        (sck),
        .shift_stb  (shift_stb),
        .sample_stb (sample_stb),
        .extlock    (extlock)
    );

    task automatic step;
        @(posedge refclk);
        #1;
    endtask

    // Edge j (1-based) of a burst lands j*(d+1) cycles after acceptance.
    function automatic int edge_at(int v, int d, int nb);
        if (v > 0 && (v % (d + 1)) == 0 && (v / (d + 1)) <= 2 * nb) return v / (d + 1);
        return 0;
    endfunction

    function automatic logic exp_sck(int v, int d, int nb, logic pol);
        int e;
        e = v / (d + 1);
        if (e > 2 * nb) e = 2 * nb;
        return pol ^ ((e % 2) == 1);
    endfunction

    function automatic logic exp_shift(int v, int d, int nb, logic pha);
        int j;
        j = edge_at(v, d, nb);
        if (v == 0) return !pha;
        if (j == 0) return 1'b0;
        if (pha) return (j % 2) == 1;
        return ((j % 2) == 0) && (j < 2 * nb);
    endfunction

    function automatic logic exp_sample(int v, int d, int nb, logic pha);
        int j;
        j = edge_at(v, d, nb);
        if (j == 0) return 1'b0;
        return pha ? ((j % 2) == 0) : ((j % 2) == 1);
    endfunction

    task automatic wait_lock(output bit locked);
        locked = 1'b0;
        step;
        for (int i = 0; i < LOCK_CYCLES + 4; i++) begin
            if (extlock) begin
                locked = 1'b1;
                break;
            end
            step;
        end
    endtask

    // Runs one burst; v is the model's cycle index, frozen while stdby is held.
    task automatic test_burst(input int d, input int n, input logic pol, input logic pha,
                              input int sb_at, input int sb_len, input int chg_at,
                              input int restart_at, output int busy_cyc, output int done_wall,
                              output int n_sh, output int n_sa);
        int nb;
        int L;
        int v;
        int wall;
        int frozen_left;
        bit adv;
        bit chg;
        bit sb_used;
        bit locked;
        logic [5:0] got;
        logic [5:0] exp;
        nb = (n == 0) ? MAX_BITS : n;
        L  = (2 * nb + 1) * (d + 1);
        div = 8'(d); cpol = pol; cpha = pha; nbits = 6'(n); stdby = 1'b0; start = 1'b0;
        wait_lock(locked);
        n_checks++;
        if (!locked) $display("FAIL burst_lock: extlock=%0b required 1", extlock);
        else n_pass++;
        n_checks++;
        if (sck !== pol) $display("FAIL burst_idle_sck: sck=%0b required %0b", sck, pol);
        else n_pass++;
        start = 1'b1;
        step;
        start = 1'b0;
        v = 0; wall = 0; adv = 1'b1; frozen_left = 0; chg = 1'b0; sb_used = 1'b0;
        busy_cyc = 0; done_wall = -1; n_sh = 0; n_sa = 0;
        while (wall <= L + sb_len + 8) begin
            exp = {v < L, adv && (v == L), exp_sck(v, d, nb, pol),
                   adv && exp_shift(v, d, nb, pha), adv && exp_sample(v, d, nb, pha), 1'b1};
            got = {busy, done, sck, shift_stb, sample_stb, extlock};
            n_checks++;
            if (got !== exp)
                $display("FAIL burst_cycle d=%0d n=%0d mode=%0b%0b wall=%0d: {busy,done,sck,shift,sample,lock}=%b required %b",
                         d, n, pol, pha, wall, got, exp);
            else n_pass++;
            if (busy === 1'b1) busy_cyc++;
            if (shift_stb === 1'b1) n_sh++;
            if (sample_stb === 1'b1) n_sa++;
            if (done === 1'b1 && done_wall < 0) done_wall = wall;
            if (adv && v == L) break;
            stdby = 1'b0;
            start = 1'b0;
            if (frozen_left > 0) begin
                stdby = 1'b1;
                frozen_left--;
            end else if (!sb_used && v == sb_at && sb_len > 0) begin
                stdby = 1'b1;
                frozen_left = sb_len - 1;
                sb_used = 1'b1;
            end
            if (wall == restart_at) start = 1'b1;
            if (wall == chg_at) begin
                div = 8'(d + 1);
                chg = 1'b1;
            end
            adv = !stdby;
            step;
            wall++;
            if (adv) v++;
        end
        stdby = 1'b0;
        start = 1'b0;
        n_checks++;
        if (done_wall != L + sb_len)
            $display("FAIL burst_done_time: done at cycle %0d required %0d", done_wall, L + sb_len);
        else n_pass++;
        step;
        n_checks++;
        if ({busy, done, extlock} !== {2'b00, !chg})
            $display("FAIL burst_after_done: {busy,done,lock}=%b required %b", {busy, done, extlock}, {2'b00, !chg});
        else n_pass++;
    endtask

    task automatic test_reset;
        logic [4:0] seen;
        int rise;
        reset = 1'b0; stdby = 1'b0; div = 8'd3; cpol = 1'b0; cpha = 1'b0; nbits = 6'd8; start = 1'b0;
`ifdef SPI_CLK_CONT_EN
        cont = 1'b0;
`endif
        #23;
        n_checks++;
        if ({busy, done, sck, shift_stb, sample_stb, extlock} !== 6'b0)
            $display("FAIL reset_values: outputs=%b required 000000",
                     {busy, done, sck, shift_stb, sample_stb, extlock});
        else n_pass++;
        @(posedge refclk);
        #1;
        reset = 1'b1;
        // First edge captures div=3, then 16 stable cycles count down to lock.
        seen = '0;
        rise = -1;
        for (int i = 1; i <= 30; i++) begin
            step;
            seen = seen | {busy, done, sck, shift_stb, sample_stb};
            if (extlock && rise < 0) rise = i;
        end
        n_checks++;
        if (rise != LOCK_CYCLES + 1)
            $display("FAIL reset_lock_time: extlock rose after edge %0d required %0d", rise, LOCK_CYCLES + 1);
        else n_pass++;
        n_checks++;
        if (seen !== 5'b0) $display("FAIL reset_quiet: outputs seen=%b required 00000", seen);
        else n_pass++;
    endtask

    task automatic test_mode0;
        logic [1:0] m;
        int bc, dw, sh, sa;
        m = SPI_MODE0;
        test_burst(1, 8, m[1], m[0], -1, 0, -1, -1, bc, dw, sh, sa);
        n_checks++;
        if (sh != 8) $display("FAIL mode0_shift_count: %0d required 8", sh); else n_pass++;
        n_checks++;
        if (sa != 8) $display("FAIL mode0_sample_count: %0d required 8", sa); else n_pass++;
        n_checks++;
        if (bc != 34) $display("FAIL mode0_busy_cycles: %0d required 34", bc); else n_pass++;
        // Acceptance cycle through done cycle inclusive.
        n_checks++;
        if (dw + 2 != 36) $display("FAIL mode0_span: %0d required 36", dw + 2); else n_pass++;
    endtask

    task automatic test_mode3;
        logic [1:0] m;
        int bc, dw, sh, sa;
        m = SPI_MODE3;
        test_burst(0, 4, m[1], m[0], -1, 0, -1, 2, bc, dw, sh, sa);
        n_checks++;
        if (sh != 4 || sa != 4) $display("FAIL mode3_strobes: shift=%0d sample=%0d required 4/4", sh, sa);
        else n_pass++;
        n_checks++;
        if (bc != 9) $display("FAIL mode3_busy_cycles: %0d required 9", bc); else n_pass++;
    endtask

    task automatic test_stdby;
        int bc0, dw0, sh0, sa0, bc1, dw1, sh1, sa1;
        test_burst(2, 6, 1'b0, 1'b0, -1, 0, -1, -1, bc0, dw0, sh0, sa0);
        test_burst(2, 6, 1'b0, 1'b0, 10, 5, -1, -1, bc1, dw1, sh1, sa1);
        n_checks++;
        if (dw1 != dw0 + 5) $display("FAIL stdby_done_delay: %0d required %0d", dw1, dw0 + 5); else n_pass++;
        n_checks++;
        if (sh1 != sh0 || sa1 != sa0)
            $display("FAIL stdby_strobes: %0d/%0d required %0d/%0d", sh1, sa1, sh0, sa0);
        else n_pass++;
    endtask

    task automatic test_div_change;
        int rise, seen_busy;
        int bc, dw, sh, sa;
        bit locked;
        div = 8'd3; stdby = 1'b0; start = 1'b0;
        wait_lock(locked);
        div = 8'd5;
        step;
        n_checks++;
        if (extlock !== 1'b0) $display("FAIL divchg_drop: extlock=%0b required 0", extlock); else n_pass++;
        start = 1'b1;
        rise = -1;
        seen_busy = 0;
        for (int i = 1; i <= 40; i++) begin
            step;
            if (busy) seen_busy++;
            if (extlock) begin
                start = 1'b0;
                rise = i;
                break;
            end
        end
        start = 1'b0;
        step;
        if (busy) seen_busy++;
        n_checks++;
        if (rise != LOCK_CYCLES) $display("FAIL divchg_relock: %0d cycles required %0d", rise, LOCK_CYCLES);
        else n_pass++;
        n_checks++;
        if (seen_busy != 0) $display("FAIL divchg_start_ignored: busy seen %0d required 0", seen_busy);
        else n_pass++;
        test_burst(2, 5, 1'b1, 1'b0, -1, 0, 4, -1, bc, dw, sh, sa);
    endtask

    task automatic test_random;
        int d, n, sb_at, sb_len, rs;
        int bc, dw, sh, sa;
        for (int it = 0; it < 8; it++) begin
            d = $urandom_range(0, 5);
            n = $urandom_range(1, 9);
            sb_at = $urandom_range(1, (2 * n + 1) * (d + 1) - 1);
            sb_len = $urandom_range(0, 4);
            rs = $urandom_range(1, 6);
            test_burst(d, n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       sb_at, sb_len, -1, rs, bc, dw, sh, sa);
        end
    endtask

    task automatic test_boundaries;
        int bc, dw, sh, sa;
        test_burst(0, 0, 1'b0, 1'b1, -1, 0, -1, -1, bc, dw, sh, sa);
        n_checks++;
        if (sh != MAX_BITS || sa != MAX_BITS)
            $display("FAIL nbits0_strobes: %0d/%0d required %0d", sh, sa, MAX_BITS);
        else n_pass++;
        test_burst(255, 1, 1'b0, 1'b0, -1, 0, -1, -1, bc, dw, sh, sa);
        n_checks++;
        if (dw != 768) $display("FAIL maxdiv_done_time: %0d required 768", dw); else n_pass++;
    endtask

    task automatic test_reset_mid_burst;
        int toggles, seen_done;
        logic prev;
        bit locked;
        div = 8'd1; cpol = 1'b1; cpha = 1'b1; nbits = 6'd8; stdby = 1'b0; start = 1'b0;
        wait_lock(locked);
        start = 1'b1;
        step;
        start = 1'b0;
        prev = sck;
        toggles = 0;
        for (int i = 0; i < 40 && toggles < 5; i++) begin
            step;
            if (sck !== prev) toggles++;
            prev = sck;
        end
        #3;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, sck, shift_stb, sample_stb, extlock} !== 6'b0 || toggles != 5)
            $display("FAIL midburst_reset: outputs=%b edges=%0d required 000000 after edge 5",
                     {busy, done, sck, shift_stb, sample_stb, extlock}, toggles);
        else n_pass++;
        @(posedge refclk);
        #1;
        reset = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            step;
            if (done || busy) seen_done++;
        end
        n_checks++;
        if (seen_done != 0) $display("FAIL midburst_no_done: busy/done seen %0d required 0", seen_done);
        else n_pass++;
    endtask

`ifdef SPI_CLK_CONT_EN
    task automatic test_cont;
        int edges, target, last_wall, done_wall, early_end;
        logic prev;
        bit locked;
        div = 8'd0; cpol = 1'b0; cpha = 1'b0; nbits = 6'd1; stdby = 1'b0; start = 1'b0; cont = 1'b1;
        wait_lock(locked);
        start = 1'b1;
        step;
        start = 1'b0;
        prev = sck;
        edges = 0; target = -1; last_wall = -1; done_wall = -1; early_end = 0;
        for (int w = 1; w <= 400; w++) begin
            step;
            if (sck !== prev) begin
                edges++;
                last_wall = w;
            end
            prev = sck;
            if (done) begin
                done_wall = w;
                break;
            end
            if (target < 0 && !busy) early_end++;
            if (target < 0 && edges == 2 * MAX_BITS + 12) begin
                cont = 1'b0;
                target = edges + 2;
            end
        end
        cont = 1'b0;
        n_checks++;
        if (early_end != 0) $display("FAIL cont_runs_on: busy low %0d times before cont dropped", early_end);
        else n_pass++;
        n_checks++;
        if (edges != target) $display("FAIL cont_last_edge: %0d edges required %0d", edges, target);
        else n_pass++;
        n_checks++;
        if (done_wall != last_wall + 1)
            $display("FAIL cont_done_time: done at %0d required %0d", done_wall, last_wall + 1);
        else n_pass++;
    endtask
`endif

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mode0();
        test_mode3();
        test_stdby();
        test_div_change();
        test_random();
        test_boundaries();
        test_reset_mid_burst();
`ifdef SPI_CLK_CONT_EN
        test_cont();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
